// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ streaming stages: framer FSM states,
// header field layout and tuser bit assignments.
package daq_pkg;

    localparam int          DATA_W_DEF       = 32;
    localparam int          TUSER_W          = 4;
    localparam logic [15:0] FRAMER_MAGIC_DEF = 16'hA5C3;

    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_MAGIC_W   = 16;
    localparam int HDR_SEQ_LSB   = 0;
    localparam int HDR_SEQ_W     = 16;

    localparam int TUSER_SOF = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } framer_state_t;

    function automatic logic [31:0] make_header(input logic [15:0] magic,
                                                input logic [15:0] seq);
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: HDR_MAGIC_W] = magic;
        h[HDR_SEQ_LSB +: HDR_SEQ_W]     = seq;
        return h;
    endfunction

endpackage

// File: rtl/axi_if.sv
// Minimal AXI-Stream bundle (tvalid/tready/tdata/tlast/tuser) with master/slave views.
interface axi_if #(
    parameter int DW = 32,
    parameter int UW = 4
) ();
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic [UW-1:0] tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream register slice. The producer may load whenever can_load is
// high; the held word stays stable until the consumer takes it.
module axis_out_reg
    import daq_pkg::*;
#(
    parameter int DW = 32,
    parameter int UW = TUSER_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_load,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic [UW-1:0] in_user,
    output logic          can_load,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [UW-1:0] out_user
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;
    logic [UW-1:0] user_q, user_d;

    assign can_load = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        user_d  = user_q;
        if (can_load) begin
            valid_d = in_load;
            if (in_load) begin
                data_d = in_data;
                last_d = in_last;
                user_d = in_user;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_user  = user_q;

endmodule

// File: rtl/sample_framer.sv
// Wraps the {ch1,ch0} sample stream into frames: one {MAGIC, seq} header word
// followed by FRAME_LEN samples, tlast on the final sample.
module sample_framer
    import daq_pkg::*;
#(
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int          FRAME_LEN = 256,
    parameter logic [15:0] MAGIC     = FRAMER_MAGIC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_if.slave        s_axi,
    axi_if.master       m_axi,
    input  logic        enable,
    output logic [15:0] frame_seq,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    framer_state_t state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   seq_q, seq_d;
    logic          busy_q, busy_d;

    logic               can_load;
    logic               s_ready;
    logic               s_hs;
    logic               cnt_last;
    logic               load;
    logic [DATA_W-1:0]  load_data;
    logic               load_last;
    logic [TUSER_W-1:0] load_user;

    logic               out_valid;
    logic               out_last;
    logic [DATA_W-1:0]  out_data;
    logic [TUSER_W-1:0] out_user;

    // Input-side tlast/tuser carry nothing the framer needs.
    logic unused_s_sideband;
    assign unused_s_sideband = ^{s_axi.tlast, s_axi.tuser};

    assign cnt_last = (cnt_q == LAST_IDX);
    assign s_ready  = (state_q == PAYLOAD) && can_load;
    assign s_hs     = s_axi.tvalid && s_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        load_user = '0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = HDR;
            end
            HDR: begin
                load                 = 1'b1;
                load_data            = make_header(MAGIC, seq_q);
                load_user[TUSER_SOF] = 1'b1;
                if (can_load) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                end
            end
            PAYLOAD: begin
                if (s_hs) begin
                    load      = 1'b1;
                    load_data = s_axi.tdata;
                    load_last = cnt_last;
                    if (cnt_last) begin
                        // Frame boundary: the only point besides IDLE where enable matters.
                        cnt_d   = '0;
                        seq_d   = seq_q + 16'd1;
                        state_d = enable ? HDR : IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == HDR) || (state_d == PAYLOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            busy_q  <= busy_d;
        end
    end

    axis_out_reg #(
        .DW (DATA_W),
        .UW (TUSER_W)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_load   (load),
        .in_data   (load_data),
        .in_last   (load_last),
        .in_user   (load_user),
        .can_load  (can_load),
        .out_valid (out_valid),
        .out_ready (m_axi.tready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_user  (out_user)
    );

    assign s_axi.tready = s_ready;
    assign m_axi.tvalid = out_valid;
    assign m_axi.tdata  = out_data;
    assign m_axi.tlast  = out_last;
    assign m_axi.tuser  = out_user;

    assign frame_done = out_valid && m_axi.tready && out_last;
    assign frame_seq  = seq_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: two instances (FRAME_LEN 4 and 1) exercised one at a time,
// outputs checked in order against a frame model built from the samples sent.
module tb_sample_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    axi_if s_if0 ();
    axi_if m_if0 ();
    axi_if s_if1 ();
    axi_if m_if1 ();

    logic [1:0]        sv, mr, en;
    logic [1:0][31:0]  sd;
    logic [1:0]        o_srdy, o_mv, o_ml, o_done, o_busy;
    logic [1:0][31:0]  o_md;
    logic [1:0][3:0]   o_mu;
    logic [1:0][15:0]  o_seq;

    assign s_if0.tvalid = sv[0];
    assign s_if0.tdata  = sd[0];
    assign s_if0.tlast  = 1'b0;
    assign s_if0.tuser  = '0;
    assign m_if0.tready = mr[0];
    assign o_srdy[0]    = s_if0.tready;
    assign o_mv[0]      = m_if0.tvalid;
    assign o_md[0]      = m_if0.tdata;
    assign o_ml[0]      = m_if0.tlast;
    assign o_mu[0]      = m_if0.tuser;

    assign s_if1.tvalid = sv[1];
    assign s_if1.tdata  = sd[1];
    assign s_if1.tlast  = 1'b0;
    assign s_if1.tuser  = '0;
    assign m_if1.tready = mr[1];
    assign o_srdy[1]    = s_if1.tready;
    assign o_mv[1]      = m_if1.tvalid;
    assign o_md[1]      = m_if1.tdata;
    assign o_ml[1]      = m_if1.tlast;
    assign o_mu[1]      = m_if1.tuser;

    logic [15:0] seq_a, seq_b;
    logic        done_a, done_b, busy_a, busy_b;
    assign o_seq[0] = seq_a;
    assign o_seq[1] = seq_b;
    assign o_done   = {done_b, done_a};
    assign o_busy   = {busy_b, busy_a};

    sample_framer #(.FRAME_LEN(4)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axi      (s_if0),
        .m_axi      (m_if0),
        .enable     (en[0]),
        .frame_seq  (seq_a),
        .frame_done (done_a),
        .busy       (busy_a)
    );

    sample_framer #(.FRAME_LEN(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axi      (s_if1),
        .m_axi      (m_if1),
        .enable     (en[1]),
        .frame_seq  (seq_b),
        .frame_done (done_b),
        .busy       (busy_b)
    );

    // Scoreboard state; words are {done, tuser[3:0], tlast, tdata}.
    localparam int W = 38;
    logic [31:0]  sent_q[$];
    logic [W-1:0] obs_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held_q[$];
    logic [W-1:0] after_q[$];
    int           hs_cyc_q[$];
    int           done_total;
    int           stall_rdy_viol;
    logic [15:0]  seq_exp[2];
    int           n_cmp = 0;
    int           n_fail = 0;

    function automatic int flen(input int w);
        return (w == 0) ? 4 : 1;
    endfunction

    // Reference model: every frame is a header then the next FRAME_LEN samples sent.
    function automatic void build_exp(input int w, input int n_frames, input logic [15:0] seq0);
        int k;
        logic last;
        k = 0;
        exp_q.delete();
        for (int f = 0; f < n_frames; f++) begin
            exp_q.push_back({1'b0, 4'b0001, 1'b0, 16'hA5C3, 16'(seq0 + 16'(f))});
            for (int j = 0; j < flen(w); j++) begin
                last = (j == flen(w) - 1);
                exp_q.push_back({last, 4'b0000, last, sent_q[k]});
                k++;
            end
        end
    endfunction

    // Drives instance w for n_frames worth of samples and records what comes out.
    task automatic run_frames(input int w, input int n_frames, input int en_stop,
                              input int vpct, input int rpct, input bit counting);
        int   total, idx, cyc, tail, exp_words;
        logic pend;
        total     = n_frames * flen(w);
        exp_words = n_frames * (flen(w) + 1);
        sent_q.delete(); obs_q.delete(); hs_cyc_q.delete();
        held_q.delete(); after_q.delete();
        done_total = 0; stall_rdy_viol = 0;
        for (int i = 0; i < total; i++)
            sent_q.push_back(counting ? {16'(i + 1), 16'(i)} : $urandom());
        idx = 0; cyc = 0; tail = 0; pend = 1'b0;
        while (cyc < 4000 && tail < 6) begin
            sv[w] = (idx < total) && ($urandom_range(99) < vpct);
            sd[w] = (idx < total) ? sent_q[idx] : 32'h0;
            mr[w] = ($urandom_range(99) < rpct);
            en[w] = (idx < en_stop);
            @(negedge clk);
            if (pend) begin
                after_q.push_back({o_mv[w], o_mu[w], o_ml[w], o_md[w]});
                pend = 1'b0;
            end
            if (o_mv[w] && !mr[w]) begin
                held_q.push_back({1'b1, o_mu[w], o_ml[w], o_md[w]});
                pend = 1'b1;
                if (o_srdy[w]) stall_rdy_viol++;
            end
            if (o_mv[w] && mr[w]) obs_q.push_back({o_done[w], o_mu[w], o_ml[w], o_md[w]});
            if (o_done[w]) done_total++;
            if (sv[w] && o_srdy[w]) begin
                hs_cyc_q.push_back(cyc);
                idx++;
            end
            if (idx == total && obs_q.size() >= exp_words) tail++;
            @(posedge clk);
            #1;
            cyc++;
        end
        sv[w] = 1'b0;
        mr[w] = 1'b1;
        en[w] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if ({o_mv[w], o_ml[w], o_mu[w], o_md[w], o_srdy[w], o_busy[w], o_done[w], o_seq[w]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got mv=%b last=%b user=%h data=%h srdy=%b busy=%b done=%b seq=%h, required all zero",
                         w, o_mv[w], o_ml[w], o_mu[w], o_md[w], o_srdy[w], o_busy[w], o_done[w], o_seq[w]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        run_frames(0, 2, 7, 100, 100, 1'b1);
        build_exp(0, 2, seq_exp[0]);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_len: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_word[%0d]: got %h, required %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            n_cmp++;
            if (hs_cyc_q[i] - hs_cyc_q[i-1] !== ((i % 4 == 0) ? 2 : 1)) begin
                n_fail++;
                $display("FAIL basic_throughput[%0d]: gap %0d, required %0d", i,
                         hs_cyc_q[i] - hs_cyc_q[i-1], (i % 4 == 0) ? 2 : 1);
            end
        end
        n_cmp++;
        if (done_total !== 2) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses, required 2", done_total);
        end
        seq_exp[0] = seq_exp[0] + 16'd2;
        @(negedge clk);
        n_cmp++;
        if (o_seq[0] !== seq_exp[0] || o_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_seq_idle: got seq=%h busy=%b, required seq=%h busy=0", o_seq[0], o_busy[0], seq_exp[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_backpressure();
        run_frames(0, 10, 39, 100, 50, 1'b0);
        build_exp(0, 10, seq_exp[0]);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_len: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_word[%0d]: got %h, required %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        for (int i = 0; i < after_q.size(); i++) begin
            n_cmp++;
            if (after_q[i] !== held_q[i]) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: got %h after stall, required %h", i, after_q[i], held_q[i]);
            end
        end
        n_cmp++;
        if (stall_rdy_viol !== 0) begin
            n_fail++;
            $display("FAIL bp_srdy_on_stall: got %0d cycles with s_tready high, required 0", stall_rdy_viol);
        end
        n_cmp++;
        if (done_total !== 10) begin
            n_fail++;
            $display("FAIL bp_done: got %0d pulses, required 10", done_total);
        end
        seq_exp[0] = seq_exp[0] + 16'd10;
    endtask

    task automatic test_input_stall();
        run_frames(0, 3, 11, 50, 100, 1'b0);
        build_exp(0, 3, seq_exp[0]);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL istall_len: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL istall_word[%0d]: got %h, required %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        seq_exp[0] = seq_exp[0] + 16'd3;
    endtask

    task automatic test_enable_drop();
        run_frames(0, 1, 2, 100, 100, 1'b1);
        build_exp(0, 1, seq_exp[0]);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL endrop_len: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL endrop_word[%0d]: got %h, required %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        seq_exp[0] = seq_exp[0] + 16'd1;
        sv[0] = 1'b1;
        sd[0] = $urandom();
        mr[0] = 1'b1;
        en[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({o_srdy[0], o_mv[0], o_busy[0]} !== 3'b000) begin
                n_fail++;
                $display("FAIL endrop_idle[%0d]: got srdy=%b mv=%b busy=%b, required 0 0 0", c, o_srdy[0], o_mv[0], o_busy[0]);
            end
            @(posedge clk);
            #1;
        end
        sv[0] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        en[0] = 1'b1;
        sv[0] = 1'b1;
        sd[0] = $urandom();
        mr[0] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mr[0] = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_mv[0], o_busy[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_pre: got mv=%b busy=%b, required 1 1", o_mv[0], o_busy[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_mv[0], o_ml[0], o_mu[0], o_md[0], o_srdy[0], o_busy[0], o_done[0], o_seq[0]} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got mv=%b last=%b user=%h data=%h srdy=%b busy=%b seq=%h, required all zero",
                     o_mv[0], o_ml[0], o_mu[0], o_md[0], o_srdy[0], o_busy[0], o_seq[0]);
        end
        sv[0] = 1'b0;
        en[0] = 1'b0;
        mr[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seq_exp[0] = 16'h0000;
        seq_exp[1] = 16'h0000;
        run_frames(0, 2, 7, 80, 80, 1'b0);
        build_exp(0, 2, seq_exp[0]);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rstmid_len: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_word[%0d]: got %h, required %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        seq_exp[0] = seq_exp[0] + 16'd2;
    endtask

    task automatic test_seq_wrap();
        @(negedge clk);
        force dut_b.seq_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut_b.seq_q;
        seq_exp[1] = 16'hFFFE;
        @(negedge clk);
        n_cmp++;
        if (o_seq[1] !== seq_exp[1]) begin
            n_fail++;
            $display("FAIL wrap_preload: got seq=%h, required %h", o_seq[1], seq_exp[1]);
        end
        @(posedge clk);
        #1;
        run_frames(1, 3, 2, 100, 100, 1'b0);
        build_exp(1, 3, seq_exp[1]);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_len: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_word[%0d]: got %h, required %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        seq_exp[1] = seq_exp[1] + 16'd3;
        @(negedge clk);
        n_cmp++;
        if (o_seq[1] !== seq_exp[1]) begin
            n_fail++;
            $display("FAIL wrap_seq_after: got seq=%h, required %h", o_seq[1], seq_exp[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_len1_stream();
        run_frames(1, 8, 7, 100, 100, 1'b0);
        build_exp(1, 8, seq_exp[1]);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL len1_len: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL len1_word[%0d]: got %h, required %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            n_cmp++;
            if (hs_cyc_q[i] - hs_cyc_q[i-1] !== 2) begin
                n_fail++;
                $display("FAIL len1_bubble[%0d]: gap %0d, required 2", i, hs_cyc_q[i] - hs_cyc_q[i-1]);
            end
        end
        n_cmp++;
        if (done_total !== 8) begin
            n_fail++;
            $display("FAIL len1_done: got %0d pulses, required 8", done_total);
        end
        seq_exp[1] = seq_exp[1] + 16'd8;
    endtask

    initial begin
        rst_n = 1'b0;
        sv = '0;
        sd = '0;
        mr = '1;
        en = '0;
        seq_exp[0] = 16'h0000;
        seq_exp[1] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        test_basic_frame();
        test_random_backpressure();
        test_input_stall();
        test_enable_drop();
        test_reset_mid_frame();
        test_seq_wrap();
        test_len1_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
